// File: rtl/menu_cursor_ctrl.sv
// menu_cursor_ctrl: debounces up/down/select buttons, steps the menu cursor with wrap,
// commits cursor moves only at frame_start and drives the cursor-box origin address.
// Optional feature: define MENU_CURSOR_AUTOREPEAT_EN to enable hold-to-repeat on up/down.
module menu_cursor_ctrl #(
   parameter int          NUM_ITEMS       = 3,
   parameter logic [18:0] BASE_ADDR       = 19'd96320,
   parameter logic [18:0] ITEM_STRIDE     = 19'd30720,
   parameter int          DEBOUNCE_CYCLES = 250000,
   parameter int          REPEAT_CYCLES   = 25000000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        btn_sel,
   input  logic        menu_active,
   input  logic        frame_start,
   output logic [18:0] startaddr,
   output logic [1:0]  item_idx,
   output logic        sel_valid,
   output logic [1:0]  sel_item
);

   localparam int              DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int              RP_W     = $clog2(REPEAT_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RP_W-1:0] RP_LAST  = RP_W'(REPEAT_CYCLES);
   localparam logic [1:0]      LAST_IDX = 2'(NUM_ITEMS - 1);
`ifdef MENU_CURSOR_AUTOREPEAT_EN
   localparam logic            RPT_EN   = 1'b1;
`else
   localparam logic            RPT_EN   = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, NAV, LOCK} state_t;

   // Button vectors are ordered {sel, down, up}.
   logic [2:0]      sync1_q, sync2_q;
   logic [2:0]      deb_q, deb_d;
   logic [2:0]      press_q, press_d;
   logic [DB_W-1:0] cnt_q [3];
   logic [DB_W-1:0] cnt_d [3];
   logic [RP_W-1:0] rpt_q [2];
   logic [RP_W-1:0] rpt_d [2];
   logic [1:0]      rpt_fire;
   logic            ev_up, ev_dn, ev_sel;

   state_t      state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic [18:0] addr_q, addr_d;
   logic        pend_up_q, pend_up_d;
   logic        pend_dn_q, pend_dn_d;
   logic        sel_valid_q, sel_valid_d;
   logic [1:0]  sel_item_q, sel_item_d;

   function automatic logic [18:0] addr_of(input logic [1:0] i);
      return BASE_ADDR + ({17'd0, i} * ITEM_STRIDE);
   endfunction

   // Debounce: a level change is accepted only after DEBOUNCE_CYCLES consecutive mismatch cycles.
   always_comb begin
      for (int b = 0; b < 3; b++) begin
         deb_d[b]   = deb_q[b];
         press_d[b] = 1'b0;
         cnt_d[b]   = '0;
         if (sync2_q[b] != deb_q[b]) begin
            if (cnt_q[b] == DB_LAST) begin
               deb_d[b]   = sync2_q[b];
               press_d[b] = sync2_q[b];
            end else begin
               cnt_d[b] = cnt_q[b] + DB_W'(1);
            end
         end
      end
   end

   // Auto-repeat: counts hold time after the initial edge; stays cleared when the feature is off.
   always_comb begin
      for (int b = 0; b < 2; b++) begin
         rpt_fire[b] = 1'b0;
         rpt_d[b]    = '0;
         if (RPT_EN && (state_q == NAV) && deb_q[b]) begin
            if (rpt_q[b] == RP_LAST) begin
               rpt_fire[b] = 1'b1;
               rpt_d[b]    = RP_W'(1);
            end else begin
               rpt_d[b] = rpt_q[b] + RP_W'(1);
            end
         end
      end
   end

   assign ev_up  = press_q[0] | rpt_fire[0];
   assign ev_dn  = press_q[1] | rpt_fire[1];
   assign ev_sel = press_q[2];

   // Menu FSM: collects pending moves, commits them at frame_start, handles selection lock.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      pend_up_d   = pend_up_q;
      pend_dn_d   = pend_dn_q;
      sel_valid_d = 1'b0;
      sel_item_d  = sel_item_q;
      case (state_q)
         IDLE: begin
            pend_up_d = 1'b0;
            pend_dn_d = 1'b0;
            if (menu_active) state_d = NAV;
         end
         NAV: begin
            if (!menu_active) begin
               state_d   = IDLE;
               pend_up_d = 1'b0;
               pend_dn_d = 1'b0;
            end else if (ev_sel) begin
               state_d     = LOCK;
               sel_valid_d = 1'b1;
               sel_item_d  = idx_q;
               pend_up_d   = 1'b0;
               pend_dn_d   = 1'b0;
            end else if (frame_start) begin
               if (pend_up_q && !pend_dn_q)
                  idx_d = (idx_q == 2'd0) ? LAST_IDX : idx_q - 2'd1;
               else if (pend_dn_q && !pend_up_q)
                  idx_d = (idx_q == LAST_IDX) ? 2'd0 : idx_q + 2'd1;
               // A press landing on the commit cycle belongs to the next frame.
               pend_up_d = ev_up;
               pend_dn_d = ev_dn;
            end else begin
               pend_up_d = pend_up_q | ev_up;
               pend_dn_d = pend_dn_q | ev_dn;
            end
         end
         LOCK: begin
            pend_up_d = 1'b0;
            pend_dn_d = 1'b0;
            if (!menu_active) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      addr_d = addr_of(idx_d);
   end

   // State and datapath registers, all cleared asynchronously.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         deb_q       <= '0;
         press_q     <= '0;
         for (int b = 0; b < 3; b++) cnt_q[b] <= '0;
         for (int b = 0; b < 2; b++) rpt_q[b] <= '0;
         state_q     <= IDLE;
         idx_q       <= 2'd0;
         addr_q      <= BASE_ADDR;
         pend_up_q   <= 1'b0;
         pend_dn_q   <= 1'b0;
         sel_valid_q <= 1'b0;
         sel_item_q  <= 2'd0;
      end else begin
         sync1_q     <= {btn_sel, btn_down, btn_up};
         sync2_q     <= sync1_q;
         deb_q       <= deb_d;
         press_q     <= press_d;
         for (int b = 0; b < 3; b++) cnt_q[b] <= cnt_d[b];
         for (int b = 0; b < 2; b++) rpt_q[b] <= rpt_d[b];
         state_q     <= state_d;
         idx_q       <= idx_d;
         addr_q      <= addr_d;
         pend_up_q   <= pend_up_d;
         pend_dn_q   <= pend_dn_d;
         sel_valid_q <= sel_valid_d;
         sel_item_q  <= sel_item_d;
      end
   end

   assign startaddr = addr_q;
   assign item_idx  = idx_q;
   assign sel_valid = sel_valid_q;
   assign sel_item  = sel_item_q;

endmodule

// File: tb/tb_menu_cursor_ctrl.sv
// Testbench for menu_cursor_ctrl with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=16.
module tb_menu_cursor_ctrl;

   logic        clk = 1'b0;
   logic        reset_n, btn_up, btn_down, btn_sel, menu_active, frame_start;
   logic [18:0] startaddr;
   logic [1:0]  item_idx;
   logic        sel_valid;
   logic [1:0]  sel_item;

   always #5 clk = ~clk;

   menu_cursor_ctrl #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(16)) dut (
      .clk(clk), .reset_n(reset_n), .btn_up(btn_up), .btn_down(btn_down),
      .btn_sel(btn_sel), .menu_active(menu_active), .frame_start(frame_start),
      .startaddr(startaddr), .item_idx(item_idx), .sel_valid(sel_valid),
      .sel_item(sel_item)
   );

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      string       nm;
      logic [1:0]  idx;
      logic [18:0] addr;
   } exp_t;
   exp_t sb_q[$];

   typedef struct {
      string       nm;
      logic        up;
      logic        dn;
      logic        sep;
      logic [1:0]  exp_idx;
   } vec_t;
   vec_t vq[$];

   logic [1:0] cur_idx;

   // Monitor: counts sel_valid high cycles and cursor index changes.
   int         sel_hi = 0;
   int         mv_cnt = 0;
   logic [1:0] prev_idx = 2'd0;
   always @(negedge clk) begin
      if (sel_valid === 1'b1) sel_hi <= sel_hi + 1;
      if (item_idx !== prev_idx) mv_cnt <= mv_cnt + 1;
      prev_idx <= item_idx;
   end

   function automatic logic [18:0] addr_tab(input logic [1:0] i);
      case (i)
         2'd0:    return 19'd96320;
         2'd1:    return 19'd127040;
         2'd2:    return 19'd157760;
         default: return 19'd0;
      endcase
   endfunction

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic add_vec(input string nm, input logic up, input logic dn,
                          input logic sep, input logic [1:0] idx);
      vec_t v;
      v.nm = nm; v.up = up; v.dn = dn; v.sep = sep; v.exp_idx = idx;
      vq.push_back(v);
   endtask

   task automatic press(input logic u, input logic d, input logic s, input logic sep);
      if (sep) begin
         btn_up = u;   tick(10); btn_up = 1'b0;   tick(10);
         btn_down = d; tick(10); btn_down = 1'b0; tick(10);
      end else begin
         btn_up = u; btn_down = d; btn_sel = s;
         tick(10);
         btn_up = 1'b0; btn_down = 1'b0; btn_sel = 1'b0;
         tick(10);
      end
   endtask

   // Pulse frame_start; cursor must be unchanged before the edge and updated right after it.
   task automatic frame_chk(input string nm, input logic [1:0] e_idx);
      exp_t e;
      e.nm = nm; e.idx = e_idx; e.addr = addr_tab(e_idx);
      sb_q.push_back(e);
      frame_start = 1'b1;
      check({nm, "_pre_idx"}, 32'(item_idx), 32'(cur_idx));
      check({nm, "_pre_addr"}, 32'(startaddr), 32'(addr_tab(cur_idx)));
      tick(1);
      frame_start = 1'b0;
      if (sb_q.size() == 0) begin
         n_checks++;
         $display("FAIL %s: scoreboard empty, got idx %0d expected an entry", nm, item_idx);
      end else begin
         e = sb_q.pop_front();
         check({e.nm, "_idx"}, 32'(item_idx), 32'(e.idx));
         check({e.nm, "_addr"}, 32'(startaddr), 32'(e.addr));
      end
      cur_idx = e_idx;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0, m0, exp_mv;
      logic [1:0] exp_final;

      add_vec("down1",     1'b0, 1'b1, 1'b0, 2'd1);
      add_vec("down2",     1'b0, 1'b1, 1'b0, 2'd2);
      add_vec("down_wrap", 1'b0, 1'b1, 1'b0, 2'd0);
      add_vec("up_wrap",   1'b1, 1'b0, 1'b0, 2'd2);
      add_vec("both_sim",  1'b1, 1'b1, 1'b0, 2'd2);
      add_vec("both_sep",  1'b1, 1'b1, 1'b1, 2'd2);
      add_vec("up",        1'b1, 1'b0, 1'b0, 2'd1);
      add_vec("none",      1'b0, 1'b0, 1'b0, 2'd1);

      reset_n = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_sel = 1'b0;
      menu_active = 1'b0; frame_start = 1'b0;
      tick(3);
      check("rst_idx", 32'(item_idx), 32'd0);
      check("rst_addr", 32'(startaddr), 32'd96320);
      check("rst_sel_valid", 32'(sel_valid), 32'd0);
      check("rst_sel_item", 32'(sel_item), 32'd0);
      reset_n = 1'b1;
      menu_active = 1'b1;
      cur_idx = 2'd0;
      tick(3);

      foreach (vq[i]) begin
         press(vq[i].up, vq[i].dn, 1'b0, vq[i].sep);
         frame_chk(vq[i].nm, vq[i].exp_idx);
      end

      // Bounce shorter than the debounce window must not produce a press.
      for (int c = 0; c < 20; c++) begin
         btn_down = ((c / 2) % 2 == 0);
         tick(1);
      end
      btn_down = 1'b0;
      tick(10);
      frame_chk("bounce", 2'd1);

      // Press event arriving on the frame_start cycle waits for the following frame.
      btn_down = 1'b1;
      tick(6);
      frame_chk("fs_coincide", 2'd1);
      btn_down = 1'b0;
      tick(10);
      frame_chk("fs_kept", 2'd2);
      press(1'b1, 1'b0, 1'b0, 1'b0);
      frame_chk("up_back", 2'd1);

      // Selection and lock.
      s0 = sel_hi;
      press(1'b0, 1'b0, 1'b1, 1'b0);
      check("sel_pulses", 32'(sel_hi - s0), 32'd1);
      check("sel_item", 32'(sel_item), 32'd1);
      check("sel_valid_low", 32'(sel_valid), 32'd0);
      press(1'b0, 1'b1, 1'b0, 1'b0);
      frame_chk("lock_down", 2'd1);
      menu_active = 1'b0; tick(2);
      menu_active = 1'b1; tick(2);
      press(1'b0, 1'b1, 1'b0, 1'b0);
      frame_chk("unlock_down", 2'd2);
      check("sel_item_held", 32'(sel_item), 32'd1);
      check("sel_no_extra", 32'(sel_hi - s0), 32'd1);

      // Asynchronous reset mid-debounce.
      btn_down = 1'b1;
      tick(3);
      reset_n = 1'b0;
      #1;
      check("arst_idx", 32'(item_idx), 32'd0);
      check("arst_addr", 32'(startaddr), 32'd96320);
      check("arst_sel_item", 32'(sel_item), 32'd0);
      check("arst_sel_valid", 32'(sel_valid), 32'd0);
      btn_down = 1'b0;
      tick(2);
      reset_n = 1'b1;
      tick(10);
      cur_idx = 2'd0;
      frame_chk("post_reset", 2'd0);

      // Held down button with frame_start every 8 cycles.
`ifdef MENU_CURSOR_AUTOREPEAT_EN
      exp_mv = 3; exp_final = 2'd0;
`else
      exp_mv = 1; exp_final = 2'd1;
`endif
      m0 = mv_cnt;
      for (int c = 0; c < 64; c++) begin
         btn_down = (c < 40);
         frame_start = (c % 8 == 7);
         tick(1);
      end
      frame_start = 1'b0;
      tick(10);
      cur_idx = exp_final;
      frame_chk("hold_flush", exp_final);
      check("hold_moves", 32'(mv_cnt - m0), 32'(exp_mv));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
